// File: rtl/vga_timing_pkg.sv
// ---------------------------------------------------------------------------
// vga_timing_pkg
// Shared constants and helpers for the VGA raster timing generator.
//   - DEF_* : default 640x480@60 timing (25.175 MHz pixel clock)
//   - line_total()  : active + porches + sync, for either axis
//   - sync_start()  : first counter value inside the sync region
//   - sync_end()    : first counter value after the sync region
//   - cnt_w()       : counter width able to hold 0..n-1
// ---------------------------------------------------------------------------
package vga_timing_pkg;

    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FP     = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BP     = 48;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BP     = 33;
    localparam int DEF_COLOR_W  = 1;
    localparam int DEF_PIPE     = 1;
    localparam int MAX_PIPE     = 8;

    function automatic int line_total(input int active, input int fp,
                                      input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

    function automatic int sync_start(input int active, input int fp);
        return active + fp;
    endfunction

    function automatic int sync_end(input int active, input int fp, input int sync);
        return active + fp + sync;
    endfunction

    function automatic int cnt_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/vga_timing_gen_delay_line.sv
// ---------------------------------------------------------------------------
// vga_delay_line
// Fixed-depth shift register used to delay the sync/active flags and the
// test-pattern colour so they line up with the sampled pixel data.
//   clk_i  : clock
//   rst_ni : asynchronous active-low clear; every stage loads RST_VAL
//   d_i    : data entering stage 0
//   q_o    : data leaving the last stage (DEPTH cycles after d_i)
// ---------------------------------------------------------------------------
module vga_delay_line #(
    parameter int               DEPTH   = 1,
    parameter int               WIDTH   = 1,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    if (DEPTH < 1) begin : g_depth_check
        $error("vga_delay_line: DEPTH must be at least 1");
    end

    logic [WIDTH-1:0] stage_q [DEPTH];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_q[i] <= RST_VAL;
            end
        end else begin
            stage_q[0] <= d_i;
            for (int i = 1; i < DEPTH; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign q_o = stage_q[DEPTH-1];

endmodule

// File: rtl/vga_timing_gen.sv
// ---------------------------------------------------------------------------
// vga_timing_gen
// Parametrised VGA raster timing generator. The early stage publishes the
// raster position to the pixel source; PIPE cycles later the source returns
// the colour, which is registered once. hSync, vSync and de travel through a
// PIPE+1 deep delay line so all four outputs change on the same edge.
//
// Optional feature: define VGA_TEST_PATTERN_EN to add test_en, which
// replaces rgbIn with eight vertical colour bars.
//
// Ports:
//   clk25175KHz          in   pixel clock
//   reset                in   asynchronous, active-low
//   test_en              in   (VGA_TEST_PATTERN_EN only) colour-bar select
//   x, y                 out  early raster counters
//   active               out  early: inside the visible area
//   line_start           out  early: x == 0
//   frame_start          out  early: x == 0 && y == 0
//   redIn/greenIn/blueIn in   colour for the x/y issued PIPE cycles earlier
//   redOut/greenOut/blueOut out registered colour, 0 outside the visible area
//   hSync, vSync, de     out  registered syncs and data-enable
// ---------------------------------------------------------------------------
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int H_ACTIVE  = DEF_H_ACTIVE,
    parameter int H_FP      = DEF_H_FP,
    parameter int H_SYNC    = DEF_H_SYNC,
    parameter int H_BP      = DEF_H_BP,
    parameter int V_ACTIVE  = DEF_V_ACTIVE,
    parameter int V_FP      = DEF_V_FP,
    parameter int V_SYNC    = DEF_V_SYNC,
    parameter int V_BP      = DEF_V_BP,
    parameter bit HSYNC_POL = 1'b0,
    parameter bit VSYNC_POL = 1'b0,
    parameter int COLOR_W   = DEF_COLOR_W,
    parameter int PIPE      = DEF_PIPE,
    localparam int H_TOTAL  = line_total(H_ACTIVE, H_FP, H_SYNC, H_BP),
    localparam int V_TOTAL  = line_total(V_ACTIVE, V_FP, V_SYNC, V_BP),
    localparam int XW       = cnt_w(H_TOTAL),
    localparam int YW       = cnt_w(V_TOTAL)
) (
    input  logic               clk25175KHz,
    input  logic               reset,
`ifdef VGA_TEST_PATTERN_EN
    input  logic               test_en,
`endif
    output logic [XW-1:0]      x,
    output logic [YW-1:0]      y,
    output logic               active,
    output logic               line_start,
    output logic               frame_start,
    input  logic [COLOR_W-1:0] redIn,
    input  logic [COLOR_W-1:0] greenIn,
    input  logic [COLOR_W-1:0] blueIn,
    output logic [COLOR_W-1:0] redOut,
    output logic [COLOR_W-1:0] greenOut,
    output logic [COLOR_W-1:0] blueOut,
    output logic               hSync,
    output logic               vSync,
    output logic               de
);

    if (PIPE < 0 || PIPE > MAX_PIPE || H_FP == 0 || H_SYNC == 0 || H_BP == 0 ||
        V_FP == 0 || V_SYNC == 0 || V_BP == 0) begin : g_param_check
        $error("vga_timing_gen: PIPE must be 0..8 and every porch/sync must be non-zero");
    end

    localparam logic [XW-1:0] X_LAST   = XW'(H_TOTAL - 1);
    localparam logic [XW-1:0] X_ACT    = XW'(H_ACTIVE);
    localparam logic [XW-1:0] HS_START = XW'(sync_start(H_ACTIVE, H_FP));
    localparam logic [XW-1:0] HS_END   = XW'(sync_end(H_ACTIVE, H_FP, H_SYNC));
    localparam logic [YW-1:0] Y_LAST   = YW'(V_TOTAL - 1);
    localparam logic [YW-1:0] Y_ACT    = YW'(V_ACTIVE);
    localparam logic [YW-1:0] VS_START = YW'(sync_start(V_ACTIVE, V_FP));
    localparam logic [YW-1:0] VS_END   = YW'(sync_end(V_ACTIVE, V_FP, V_SYNC));

    // ---- early stage: raster counters ----
    logic [XW-1:0] x_q, x_d;
    logic [YW-1:0] y_q, y_d;

    always_comb begin
        x_d = x_q + XW'(1);
        y_d = y_q;
        if (x_q == X_LAST) begin
            x_d = '0;
            // y advances on the same edge x wraps, and wraps itself on the last line
            y_d = (y_q == Y_LAST) ? '0 : y_q + YW'(1);
        end
    end

    always_ff @(posedge clk25175KHz or negedge reset) begin
        if (!reset) begin
            x_q <= '0;
            y_q <= '0;
        end else begin
            x_q <= x_d;
            y_q <= y_d;
        end
    end

    logic active_e;
    logic hs_raw;
    logic vs_raw;

    assign active_e    = (x_q < X_ACT) && (y_q < Y_ACT);
    assign hs_raw      = (x_q >= HS_START && x_q < HS_END) ? HSYNC_POL : ~HSYNC_POL;
    assign vs_raw      = (y_q >= VS_START && y_q < VS_END) ? VSYNC_POL : ~VSYNC_POL;

    assign x           = x_q;
    assign y           = y_q;
    assign active      = active_e;
    assign line_start  = (x_q == '0);
    assign frame_start = (x_q == '0) && (y_q == '0);

    // ---- late stage: flags delayed by PIPE+1 to meet the registered colour ----
    localparam logic [2:0] SYNC_RST = {1'b0, ~VSYNC_POL, ~HSYNC_POL};

    logic [2:0] sync_q;

    vga_delay_line #(
        .DEPTH   (PIPE + 1),
        .WIDTH   (3),
        .RST_VAL (SYNC_RST)
    ) u_sync_line (
        .clk_i  (clk25175KHz),
        .rst_ni (reset),
        .d_i    ({active_e, vs_raw, hs_raw}),
        .q_o    (sync_q)
    );

    assign hSync = sync_q[0];
    assign vSync = sync_q[1];
    assign de    = sync_q[2];

`ifdef VGA_TEST_PATTERN_EN
    // Bar index k = floor(x*8/H_ACTIVE); only meaningful while x is visible,
    // and the output is blanked elsewhere anyway.
    logic [2:0] bar_e;
    logic [2:0] bar_q;
    logic       ten_q;

    assign bar_e = 3'({x_q, 3'b000} / (XW+3)'(H_ACTIVE));

    vga_delay_line #(
        .DEPTH   (PIPE + 1),
        .WIDTH   (3),
        .RST_VAL (3'b000)
    ) u_pattern_line (
        .clk_i  (clk25175KHz),
        .rst_ni (reset),
        .d_i    (bar_e),
        .q_o    (bar_q)
    );
`endif

    // rgbIn for pixel p arrives PIPE cycles after p was issued; one register
    // here brings it to the same edge as the last delay-line tap.
    logic [COLOR_W-1:0] red_q, green_q, blue_q;

    always_ff @(posedge clk25175KHz or negedge reset) begin
        if (!reset) begin
            red_q   <= '0;
            green_q <= '0;
            blue_q  <= '0;
`ifdef VGA_TEST_PATTERN_EN
            ten_q   <= 1'b0;
`endif
        end else begin
            red_q   <= redIn;
            green_q <= greenIn;
            blue_q  <= blueIn;
`ifdef VGA_TEST_PATTERN_EN
            ten_q   <= test_en;
`endif
        end
    end

    always_comb begin
        redOut   = '0;
        greenOut = '0;
        blueOut  = '0;
        if (de) begin
            redOut   = red_q;
            greenOut = green_q;
            blueOut  = blue_q;
`ifdef VGA_TEST_PATTERN_EN
            if (ten_q) begin
                redOut   = {COLOR_W{bar_q[2]}};
                greenOut = {COLOR_W{bar_q[1]}};
                blueOut  = {COLOR_W{bar_q[0]}};
            end
`endif
        end
    end

endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Parametrised VGA raster timing generator with a pixel-path pipeline; successor to the fixed 640x480 sync counter. It produces pixel coordinates for the pixel source one stage early, then samples the returned colour. It re-aligns hSync, vSync, data-enable and RGB so all four leave on the same clock edge. It sits between the framebuffer/renderer and the VGA DAC pins.

## Interface
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, horizontal sync width
- H_BP, 48, horizontal back porch
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width
- V_BP, 33, vertical back porch
- HSYNC_POL, 0, sync active level (0 = active-low)
- VSYNC_POL, 0, sync active level
- COLOR_W, 1, bits per colour channel
- PIPE, 1, cycles from x/y out to rgbIn valid (0..8)

Ports:
- clk25175KHz  in  1  pixel clock
- reset  in  1  asynchronous, active-low
- x  out  $clog2(H_TOTAL)  early horizontal counter
- y  out  $clog2(V_TOTAL)  early vertical counter
- active  out  1  early: x < H_ACTIVE && y < V_ACTIVE
- line_start  out  1  early: pulse when x == 0
- frame_start  out  1  early: pulse when x == 0 && y == 0
- redIn, greenIn, blueIn  in  COLOR_W each  pixel for the x/y issued PIPE cycles earlier
- redOut, greenOut, blueOut  out  COLOR_W each  registered colour, 0 outside active
- hSync, vSync  out  1  registered syncs
- de  out  1  registered data-enable

## Operation
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800); V_TOTAL analogous (525).
- Line order is active, front porch, sync, back porch. hSync is active for x in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC), i.e. 656..751. vSync is active for y in 490..491.
- x increments every clock and wraps H_TOTAL-1 -> 0.
- y increments only on the x wrap and wraps V_TOTAL-1 -> 0 on the same edge.
- The early stage is x, y, active, line_start, frame_start, all derived from the counter registers.
- The late stage is a PIPE+1 deep delay line carrying hSync-raw, vSync-raw and active.
  - hSync/vSync/de come from the last delay-line tap.
  - rgbOut is rgbIn registered once, forced to 0 when the delayed active is 0.
- Sync output level is the *_POL value when in the sync region, and its inverse otherwise.
- Reset (asserted low, any time, mid-frame included) takes effect immediately:
  - x, y = 0; all delay stages cleared to inactive.
  - hSync = ~HSYNC_POL, vSync = ~VSYNC_POL, de = 0, rgbOut = 0.
  - line_start and frame_start follow the counters, so both read 1 while in reset.
- No parameter range checking at runtime; an elaboration error is raised if PIPE > 8 or any porch/sync is 0.

## Timing
- x/y -> rgbIn: PIPE cycles, owned by the pixel source.
- rgbIn -> rgbOut: 1 cycle.
- Counters -> hSync/vSync/de/rgbOut: exactly PIPE+1 cycles, all four coincident.
- The first edge after reset deassertion produces x = 1. The counters do not run until reset is released.
- Frame period: H_TOTAL*V_TOTAL = 420000 cycles at defaults.
- frame_start is 1 for one cycle per frame. line_start is 1 for one cycle per line, including blanking lines.

## Configuration
- VGA_TEST_PATTERN_EN defined:
  - Adds input port test_en (1 bit).
  - When test_en = 1, rgbIn is ignored. Colour is 8 vertical bars with bar index k = floor(x*8/H_ACTIVE): red = k[2], green = k[1], blue = k[0], each replicated to COLOR_W.
  - The pattern is computed in the early stage and delayed so it aligns with de.
  - test_en is sampled per pixel.
- Not defined: the test_en port is absent and rgbOut comes solely from rgbIn.

## Structure
- Package vga_timing_pkg holds the default 640x480@60 constants, H_TOTAL/V_TOTAL and sync-region start/end computation functions, and the counter-width helper.
- Sub-module vga_delay_line holds a parametrised depth and width shift register with async active-low clear to a given reset value. It is used for the sync/active pipeline and the test-pattern path.

## Test plan
- Defaults, PIPE = 1, release reset:
  - hSync first goes low 658 cycles after release (x = 656 + 2 stages) and stays low 96 cycles.
  - de is high for 640 cycles per line.
- Run one frame:
  - frame_start pulses every 420000 cycles.
  - vSync is low for exactly 1600 cycles beginning with line 490.
  - x = 799 -> 0 and y = 524 -> 0 wrap on the same edge.
- PIPE = 4, rgbIn = x[0] echoed by a 4-stage model:
  - redOut alternates 0,1 starting with the first de cycle.
  - redOut is 0 whenever de = 0.
- HSYNC_POL = 1, VSYNC_POL = 1: syncs idle low, pulse high with identical positions; reset value is 0.
- Assert reset at x = 300, y = 200 for 3 cycles:
  - Outputs go inactive immediately.
  - After release, timing restarts from x = 0, y = 0 with no partial pulses.
- With VGA_TEST_PATTERN_EN and test_en = 1: pixels 0..79 output black and pixels 560..639 output white (r = g = b = 1).
